// File: rtl/ntwrk_topk_reduce_pkg.sv
// Shared types for the top-K network-size reducer: reduction mode and FSM states.
package aoc_types_pkg;

  typedef enum logic {
    MODE_PROD = 1'b0,
    MODE_SUM  = 1'b1
  } ntwrk_mode_e;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REDUCE  = 2'd1,
    OUT     = 2'd2
  } ntwrk_red_state_e;

endpackage

// File: rtl/ntwrk_topk_reduce_topk_ins.sv
// Sorted (descending) bank of the TOP_K largest sizes seen so far.
// A new size is inserted in one cycle: it lands above the first entry it
// strictly exceeds, everything below shifts down and the smallest falls off.
// Equal values therefore settle below the entries already present.
module topk_ins #(
  parameter int SZ_W  = 10,
  parameter int TOP_K = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            ins,
  input  logic [SZ_W-1:0] sz_in,
  output logic [SZ_W-1:0] bank [TOP_K]
);

  logic [TOP_K-1:0] gt;
  logic [SZ_W-1:0]  nxt [TOP_K];

  // Per-slot next value: keep, take the new size, or take the slot above.
  for (genvar g = 0; g < TOP_K; g++) begin : g_slot
    assign gt[g] = (sz_in > bank[g]);
    if (g == 0) begin : g_top
      assign nxt[g] = gt[g] ? sz_in : bank[g];
    end else begin : g_rest
      assign nxt[g] = !gt[g] ? bank[g] : (gt[g-1] ? bank[g-1] : sz_in);
    end
  end

  // Bank register: cleared by reset or end-of-answer, loaded on insert.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < TOP_K; i++) bank[i] <= '0;
    end else if (ins) begin
      for (int i = 0; i < TOP_K; i++) bank[i] <= nxt[i];
    end
  end

endmodule

// File: rtl/ntwrk_topk_reduce.sv
// Keeps the TOP_K largest network sizes of a stream, then reduces them one
// entry per cycle into a product or sum and offers it on a valid/ready port.
// Optional build macro NTWRK_TOPK_REDUCE_SAT_EN: tracks overflow beyond
// ANS_W, saturates the answer to all ones and reports ovf. Without it the
// answer wraps modulo 2^ANS_W and ovf is constant 0.
module ntwrk_topk_reduce
  import aoc_types_pkg::*;
#(
  parameter int SZ_W  = 10,
  parameter int TOP_K = 3,
  parameter int ANS_W = SZ_W * TOP_K
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SZ_W-1:0]  sz_in,
  input  logic             sz_vld,
  input  logic             sz_last,
  output logic             sz_rdy,
  input  logic             mode,
  output logic [ANS_W-1:0] answer,
  output logic             answer_vld,
  input  logic             answer_rdy,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(TOP_K + 1);

  ntwrk_red_state_e state;
  ntwrk_mode_e      mode_q;
  ntwrk_mode_e      eff_mode;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] idx;
  logic [ANS_W-1:0] acc;
  logic [ANS_W-1:0] answer_q;
  logic [ANS_W-1:0] step_val;
  logic [SZ_W-1:0]  cur;
  logic [SZ_W-1:0]  bank [TOP_K];
  logic             accept;
  logic             xfer;
  logic             step_last;

  assign sz_rdy     = (state == COLLECT);
  assign answer_vld = (state == OUT);
  assign busy       = (state != COLLECT);
  assign answer     = answer_q;

  assign accept    = sz_vld && sz_rdy;
  assign xfer      = answer_vld && answer_rdy;
  assign cnt_inc   = (cnt == CNT_W'(TOP_K)) ? cnt : cnt + 1'b1;
  assign eff_mode  = (cnt == '0) ? ntwrk_mode_e'(mode) : mode_q;
  assign step_last = (idx == cnt - 1'b1);

  topk_ins #(
    .SZ_W  (SZ_W),
    .TOP_K (TOP_K)
  ) u_ins (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (xfer),
    .ins   (accept),
    .sz_in (sz_in),
    .bank  (bank)
  );

  // Select the bank entry consumed by the current reduction step.
  always_comb begin
    cur = '0;
    for (int i = 0; i < TOP_K; i++) begin
      if (idx == CNT_W'(i)) cur = bank[i];
    end
  end

`ifdef NTWRK_TOPK_REDUCE_SAT_EN
  logic [2*ANS_W-1:0] step_wide;
  logic               step_ovf;
  logic               flag;
  logic               flag_nxt;

  // One reduction step at double width so overflow can be seen.
  always_comb begin
    if (mode_q == MODE_SUM) step_wide = (2*ANS_W)'(acc) + (2*ANS_W)'(cur);
    else                    step_wide = (2*ANS_W)'(acc) * (2*ANS_W)'(cur);
  end

  assign step_ovf = |step_wide[2*ANS_W-1:ANS_W];
  assign step_val = step_wide[ANS_W-1:0];
  assign flag_nxt = flag | step_ovf;
  assign ovf      = flag & answer_vld;

  // Sticky overflow flag for the stream being reduced.
  always_ff @(posedge clk) begin
    if (!rst_n || xfer)        flag <= 1'b0;
    else if (state == REDUCE)  flag <= flag_nxt;
  end
`else
  // One reduction step, wrapping at ANS_W bits.
  always_comb begin
    if (mode_q == MODE_SUM) step_val = acc + ANS_W'(cur);
    else                    step_val = acc * ANS_W'(cur);
  end

  assign ovf = 1'b0;
`endif

  // Control FSM, beat counter, accumulator and answer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= COLLECT;
      mode_q   <= MODE_PROD;
      cnt      <= '0;
      idx      <= '0;
      acc      <= '0;
      answer_q <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            cnt    <= cnt_inc;
            mode_q <= eff_mode;
            if (sz_last) begin
              state <= REDUCE;
              idx   <= '0;
              acc   <= (eff_mode == MODE_SUM) ? '0 : ANS_W'(1);
            end
          end
        end
        REDUCE: begin
          acc <= step_val;
          idx <= idx + 1'b1;
          if (step_last) begin
            state <= OUT;
`ifdef NTWRK_TOPK_REDUCE_SAT_EN
            answer_q <= flag_nxt ? '1 : step_val;
`else
            answer_q <= step_val;
`endif
          end
        end
        OUT: begin
          if (answer_rdy) begin
            state <= COLLECT;
            cnt   <= '0;
            idx   <= '0;
            acc   <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_ntwrk_topk_reduce.sv
// Self-checking bench for ntwrk_topk_reduce: a default instance (TOP_K=3,
// ANS_W=30) and a narrow instance (TOP_K=2, ANS_W=16). Expected answers come
// from sorting the whole stream and reducing its largest entries arithmetically.
// Honours NTWRK_TOPK_REDUCE_SAT_EN for the expected answer/ovf behaviour.
module tb_ntwrk_topk_reduce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [9:0] sz_in;
  logic       sz_vld, sz_last, mode, answer_rdy;
  bit         use_b;

  logic        sz_rdy_a, answer_vld_a, ovf_a, busy_a;
  logic [29:0] answer_a;
  logic        sz_rdy_b, answer_vld_b, ovf_b, busy_b;
  logic [15:0] answer_b;

  logic [63:0] cur_answer;
  logic        cur_vld, cur_rdy, cur_ovf, cur_busy;

  int n_cmp = 0;
  int n_bad = 0;

  ntwrk_topk_reduce dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .sz_in      (use_b ? 10'd0 : sz_in),
    .sz_vld     (!use_b && sz_vld),
    .sz_last    (!use_b && sz_last),
    .sz_rdy     (sz_rdy_a),
    .mode       (!use_b && mode),
    .answer     (answer_a),
    .answer_vld (answer_vld_a),
    .answer_rdy (!use_b && answer_rdy),
    .ovf        (ovf_a),
    .busy       (busy_a)
  );

  ntwrk_topk_reduce #(.SZ_W(10), .TOP_K(2), .ANS_W(16)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .sz_in      (use_b ? sz_in : 10'd0),
    .sz_vld     (use_b && sz_vld),
    .sz_last    (use_b && sz_last),
    .sz_rdy     (sz_rdy_b),
    .mode       (use_b && mode),
    .answer     (answer_b),
    .answer_vld (answer_vld_b),
    .answer_rdy (use_b && answer_rdy),
    .ovf        (ovf_b),
    .busy       (busy_b)
  );

  always_comb begin
    cur_answer = use_b ? 64'(answer_b) : 64'(answer_a);
    cur_vld    = use_b ? answer_vld_b : answer_vld_a;
    cur_rdy    = use_b ? sz_rdy_b     : sz_rdy_a;
    cur_ovf    = use_b ? ovf_b        : ovf_a;
    cur_busy   = use_b ? busy_b       : busy_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sort the stream descending, reduce the top k entries exactly.
  task automatic ref_model(input int vals[$], input bit md, input int k, input int aw,
                           output logic [63:0] ans, output logic ov);
    int     s[$];
    int     n;
    int     t;
    longint a;
    logic   big;
    s = vals;
    for (int i = 0; i < s.size(); i++)
      for (int j = i + 1; j < s.size(); j++)
        if (s[j] > s[i]) begin t = s[i]; s[i] = s[j]; s[j] = t; end
    n   = (s.size() < k) ? s.size() : k;
    a   = md ? 64'd0 : 64'd1;
    big = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = md ? a + longint'(s[i]) : a * longint'(s[i]);
      if (a >= (longint'(1) <<< aw)) big = 1'b1;
    end
`ifdef NTWRK_TOPK_REDUCE_SAT_EN
    ans = big ? ((64'd1 << aw) - 64'd1) : 64'(a);
    ov  = big;
`else
    ans = 64'(a) & ((64'd1 << aw) - 64'd1);
    ov  = 1'b0;
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sz_rdy"}, 64'(cur_rdy), 64'd1);
    check({tag, "_answer"}, cur_answer, 64'd0);
    check({tag, "_vld"}, 64'(cur_vld), 64'd0);
    check({tag, "_ovf"}, 64'(cur_ovf), 64'd0);
    check({tag, "_busy"}, 64'(cur_busy), 64'd0);
  endtask

  // Drive one stream, wait for the answer, optionally stall, then take it.
  task automatic run_stream(input int vals[$], input bit md, input bit b, input int hold);
    int          k, aw, n, lat;
    logic [63:0] ans;
    logic        ov;
    use_b = b;
    k     = b ? 2 : 3;
    aw    = b ? 16 : 30;
    ref_model(vals, md, k, aw, ans, ov);
    n = (vals.size() < k) ? vals.size() : k;
    for (int i = 0; i < vals.size(); i++) begin
      check("sz_rdy_collect", 64'(cur_rdy), 64'd1);
      sz_in   = 10'(vals[i]);
      sz_vld  = 1'b1;
      sz_last = (i == vals.size() - 1);
      mode    = (i == 0) ? md : ~md;
      tick();
    end
    sz_vld  = 1'b0;
    sz_last = 1'b0;
    lat = 0;
    while (!cur_vld && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(n));
    check("answer", cur_answer, ans);
    check("ovf", 64'(cur_ovf), 64'(ov));
    check("busy_out", 64'(cur_busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      sz_vld  = 1'b1;
      sz_in   = 10'd50;
      sz_last = 1'b1;
      tick();
      check("hold_answer", cur_answer, ans);
      check("hold_vld", 64'(cur_vld), 64'd1);
      check("hold_sz_rdy", 64'(cur_rdy), 64'd0);
      check("hold_busy", 64'(cur_busy), 64'd1);
    end
    sz_vld     = 1'b0;
    sz_last    = 1'b0;
    answer_rdy = 1'b1;
    tick();
    answer_rdy = 1'b0;
    check("post_vld", 64'(cur_vld), 64'd0);
    check("post_sz_rdy", 64'(cur_rdy), 64'd1);
    check("post_busy", 64'(cur_busy), 64'd0);
  endtask

  initial begin
    int q[$];
    int len, range;
    bit md;

    rst_n = 1'b0; sz_in = '0; sz_vld = 1'b0; sz_last = 1'b0;
    mode = 1'b0; answer_rdy = 1'b0; use_b = 1'b0;
    tick(); tick();
    use_b = 1'b0; check_reset_vals("reset_a");
    use_b = 1'b1; check_reset_vals("reset_b");
    rst_n = 1'b1;
    tick();

    $display("[TB] product 5,2,9,4");
    q = {5, 2, 9, 4};       run_stream(q, 1'b0, 1'b0, 0);
    $display("[TB] product single 7");
    q = {7};                run_stream(q, 1'b0, 1'b0, 0);
    $display("[TB] sum 1,10,3,10");
    q = {1, 10, 3, 10};     run_stream(q, 1'b1, 1'b0, 0);
    $display("[TB] stalled answer then fresh stream");
    q = {2, 3};             run_stream(q, 1'b1, 1'b0, 5);
    q = {1, 2};             run_stream(q, 1'b1, 1'b0, 0);
    $display("[TB] narrow instance overflow 1000*1000");
    q = {1000, 1000};       run_stream(q, 1'b0, 1'b1, 0);

    $display("[TB] random streams");
    for (int s = 0; s < 12; s++) begin
      len   = $urandom_range(1, 6);
      range = (s % 2 == 0) ? 7 : 1023;
      md    = 1'($urandom_range(0, 1));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back($urandom_range(0, range));
      run_stream(q, md, (s >= 8), 0);
    end

    $display("[TB] reset mid-reduce");
    use_b = 1'b0;
    q = {5, 6, 7};
    for (int i = 0; i < 3; i++) begin
      sz_in = 10'(q[i]); sz_vld = 1'b1; sz_last = (i == 2); mode = 1'b0;
      tick();
    end
    sz_vld = 1'b0; sz_last = 1'b0;
    check("mid_reduce_busy", 64'(cur_busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_vals("reset_mid");
    q = {3, 3, 3};          run_stream(q, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ntwrk_topk_reduce.md
# ntwrk_topk_reduce

Sequential replacement for the combinational network-size product at the end of the junction-box pipeline. It takes a stream of network sizes from the union stage and keeps the TOP_K largest in a sorted bank. At end of stream it reduces them over several cycles into one answer, either a product or a sum. The answer leaves through a valid/ready handshake.

## Interface
- SZ_W, default 10: width of one network size
- TOP_K, default 3: number of largest sizes kept and reduced (≥1)
- ANS_W, default SZ_W*TOP_K: answer width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- sz_in  in  SZ_W  network size
- sz_vld  in  1  sz_in valid
- sz_last  in  1  final size of stream; qualified by sz_vld
- sz_rdy  out  1  block accepts sizes
- mode  in  1  0 = product, 1 = sum; sampled on first accepted beat of a stream
- answer  out  ANS_W  reduced result
- answer_vld  out  1  answer valid
- answer_rdy  in  1  downstream accepts answer
- ovf  out  1  result overflowed ANS_W; qualified by answer_vld
- busy  out  1  high in REDUCE or OUT

## Operation
- States:
  - COLLECT (reset state): sz_rdy=1.
  - REDUCE: sz_rdy=0.
  - OUT: sz_rdy=0, answer_vld=1.
- A beat is accepted when sz_vld && sz_rdy.
- Bank is TOP_K entries, sorted descending, reset to 0.
- On each accepted beat, insert sz_in in a single cycle. Compare it against all entries. If it is strictly greater than entry i, it takes slot i and lower entries shift down; the smallest entry drops off. Ties insert below the existing equal entries.
- cnt counts accepted beats and saturates at TOP_K. n = cnt after the last beat (1..TOP_K).
- The first beat (cnt==0) latches mode for the whole stream.
- COLLECT→REDUCE on an accepted beat with sz_last=1. That beat is inserted too.
- REDUCE runs one step per cycle for i = 0..n-1:
  - Product: acc = acc*bank[i], acc initialised to 1.
  - Sum: acc = acc+bank[i], acc initialised to 0.
  - Unfilled entries (i ≥ n) never take part.
- Each step is computed at 2*ANS_W bits. If any bit above ANS_W is nonzero, the overflow flag is set, and it stays set (sticky) for the stream.
- REDUCE→OUT after step n-1. answer = acc, ovf = flag.
- OUT holds answer, answer_vld and ovf stable until answer_rdy=1.
- OUT→COLLECT on the transfer cycle. On that transition the bank, cnt, acc and flag clear, and answer_vld drops the next cycle.
- sz_vld during REDUCE/OUT is ignored: nothing is inserted and no state changes.

## Timing
- Reset values: sz_rdy=1, answer=0, answer_vld=0, ovf=0, busy=0, bank=0, cnt=0.
- Last beat accepted at cycle T:
  - REDUCE during T+1..T+n.
  - answer_vld=1 from T+n+1.
- If answer_rdy=1 on the first OUT cycle, the transfer happens that cycle and sz_rdy=1 the next cycle. Minimum answer_vld width is 1 cycle.
- rst_n=0 in any state, including mid-REDUCE or during OUT, restores all reset values on the next edge. A partial stream is discarded.
- Insertion has no extra latency. A beat accepted at cycle t is visible in the bank at t+1.

## Configuration
- NTWRK_TOPK_REDUCE_SAT_EN defined:
  - On overflow, answer = all ones.
  - ovf=1 while answer_vld=1.
- NTWRK_TOPK_REDUCE_SAT_EN undefined:
  - answer is the exact result modulo 2^ANS_W.
  - ovf is tied to 0 and the overflow flag logic is not built.

## Structure
- aoc_types_pkg holds:
  - ntwrk_mode_e: MODE_PROD=0, MODE_SUM=1.
  - ntwrk_red_state_e: COLLECT, REDUCE, OUT.
- One sub-module, topk_ins, parameters SZ_W and TOP_K. It holds the sorted register bank and the single-cycle insert, with clear and insert enables, and exposes the bank as an unpacked array.
- The top level holds the FSM, cnt, the accumulator, overflow/saturation logic and the output register.

## Test plan
1. Defaults, product, sizes 5,2,9,4 (last on 4) → bank 9,5,4; answer=180, ovf=0, answer_vld exactly 4 cycles after the last beat.
2. Product, single size 7 with last → n=1, answer=7 two cycles after the beat; also checks that unfilled entries are excluded.
3. Sum, sizes 1,10,3,10 → bank 10,10,3; answer=23.
4. answer_rdy held low 5 cycles with sz_vld=1 and sz_in=50 → answer stable, sz_rdy=0, busy=1. After the transfer the next stream's bank contains no 50.
5. SZ_W=10, TOP_K=2, ANS_W=16, product 1000,1000:
   - With SAT_EN: answer=0xFFFF, ovf=1.
   - Without SAT_EN: answer=16960, ovf=0.
6. rst_n=0 for one cycle mid-REDUCE → all outputs at reset values. The following stream 3,3,3 product gives answer=27.
